// File: rtl/data_mem_port.sv
// Purpose : initiator side of the 19-bit CPU data-memory port; computes base+offset,
//           range-checks it, drives one RAM access and returns a registered response.
// Latency : request handshake -> rsp_valid after 3 cycles (load), 2 (store), 1 (range error).
// Backpressure: one request in flight; req_ready is low until the response handshakes,
//           and rsp_* are held stable while rsp_ready is low.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_we, req_base, req_off,     request: store flag, base, signed offset,
//   req_wdata, req_rd                       store data, destination tag
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata, rsp_rd, rsp_we,     response: load data, echoed tag, echoed we,
//   rsp_err                                  out-of-range flag
//   mem_en, mem_we, mem_addr,      single-port RAM controls (active only in ACCESS)
//   mem_din, mem_dout
//   load_cnt, store_cnt, err_cnt   saturating completion counters
module data_mem_port #(
    parameter int DATA_W    = 19,
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 1024,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_off,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_rd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [2:0]        rsp_rd,
    output logic              rsp_we,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [CNT_W-1:0]  load_cnt,
    output logic [CNT_W-1:0]  store_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    localparam logic [DATA_W-1:0] DEPTH = DATA_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0]  CMAX  = {CNT_W{1'b1}};

    state_t            state;
    logic [DATA_W-1:0] ea;
    logic              ea_ok;
    logic              req_fire;

    // Offset is sign-extended to the full data width; the sum wraps modulo 2^DATA_W,
    // so small bases with negative offsets land near the top and fail the range check.
    assign ea       = req_base + {{(DATA_W-ADDR_W){req_off[ADDR_W-1]}}, req_off};
    assign ea_ok    = (ea < DEPTH);

    // Combinational so it is low during reset and high on the very first cycle after.
    assign req_ready = (state == IDLE) && !rst;
    assign req_fire  = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_rd    <= '0;
            rsp_we    <= 1'b0;
            rsp_err   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            load_cnt  <= '0;
            store_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        rsp_we    <= req_we;
                        rsp_rd    <= req_rd;
                        rsp_rdata <= '0;
                        if (ea_ok) begin
                            rsp_err  <= 1'b0;
                            // RAM controls are registered here so they are valid for
                            // exactly the ACCESS cycle; mem_din doubles as the store-data latch.
                            mem_en   <= 1'b1;
                            mem_we   <= req_we;
                            mem_addr <= ea[ADDR_W-1:0];
                            mem_din  <= req_wdata;
                            state    <= ACCESS;
                        end else begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                    mem_addr <= '0;
                    mem_din  <= '0;
                    if (rsp_we) begin
                        // Stores skip CAPTURE; whatever the RAM drives on mem_dout is ignored.
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rsp_rdata <= mem_dout;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        if (rsp_err) begin
                            if (err_cnt != CMAX) err_cnt <= err_cnt + 1'b1;
                        end else if (rsp_we) begin
                            if (store_cnt != CMAX) store_cnt <= store_cnt + 1'b1;
                        end else begin
                            if (load_cnt != CMAX) load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
